data_unpacker: RTL

// - Inverse of the trace data packer: takes packed N-wide vectors and re-emits them as beats of N, M or 1 values.
// - Beat width per chain is selected by firmware.
// - Sits between trace-buffer readout and per-chain consumers that expect their native vector length.
// - Ready/valid on both sides; one input vector may produce up to N output beats.

---
 rtl/data_unpacker.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/data_unpacker.sv
// data_unpacker: re-emits packed N-element trace vectors as beats of N, M or 1
// elements, with the beat width per chain chosen by a shift-loaded firmware table.
// Optional feature macro: UNPACKER_STATS_EN adds a saturating dropped_count output.
module data_unpacker #(
  parameter int unsigned N                  = 8,
  parameter int unsigned M                  = 2,
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned MAX_CHAINS         = 4,
  parameter int unsigned PERSONAL_CONFIG_ID = 0,
  parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE = '0,
  localparam int unsigned CW  = $clog2(N+1),
  localparam int unsigned CHW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tracing,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic [CHW-1:0]          chainId_in,
  input  logic [CW-1:0]           count_in,
  input  logic [N*DATA_WIDTH-1:0] vector_in,
  input  logic [7:0]              configId,
  input  logic [7:0]              configData,
  output logic [N*DATA_WIDTH-1:0] vector_out,
  output logic [CW-1:0]           length_out,
  output logic                    valid_out,
  input  logic                    ready_in
`ifdef UNPACKER_STATS_EN
  ,
  output logic [15:0]             dropped_count
`endif
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef logic [N-1:0][DATA_WIDTH-1:0] elems_t;
  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_e;

  state_e        state_q, state_d;
  elems_t        buf_q, buf_d, beat_q, beat_d, vin_shift;
  logic [CW-1:0] rem_q, rem_d, len_q, len_d, beat_len_q, beat_len_d;
  logic [CW-1:0] cnt_sat, fw_len, first_len, step_len;
  logic [7:0]    fw_q [MAX_CHAINS];
  logic          fw_drop, empty_vec, accept, take, last_beat;

  // Move element i+sh to element i, zero-filling the top.
  function automatic elems_t shift_dn(input elems_t v, input int unsigned sh);
    elems_t r;
    r = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i + sh < N) r[IW'(i)] = v[IW'(i + sh)];
    end
    return r;
  endfunction

  // Keep only the lowest n elements.
  function automatic elems_t keep_lo(input elems_t v, input int unsigned n);
    elems_t r;
    r = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i < n) r[IW'(i)] = v[IW'(i)];
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] min_cw(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Decode the incoming vector: saturated count, firmware beat length, first beat size.
  always_comb begin
    cnt_sat = (count_in > CW'(N)) ? CW'(N) : count_in;
    fw_drop = 1'b0;
    fw_len  = CW'(N);
    case (fw_q[chainId_in])
      8'd0:    fw_len  = CW'(N);
      8'd1:    fw_len  = CW'(M);
      8'd2:    fw_len  = CW'(1);
      default: fw_drop = 1'b1;
    endcase
    empty_vec = fw_drop | (cnt_sat == '0);
    vin_shift = shift_dn(elems_t'(vector_in), 32'(N) - 32'(cnt_sat));
    first_len = min_cw(fw_len, cnt_sat);
    step_len  = min_cw(len_q, rem_q);
  end

  // Handshake qualifiers; rem_q counts elements still queued behind the presented beat.
  assign take      = (state_q == EMIT) & ready_in;
  assign last_beat = take & (rem_q == '0);
  assign accept    = valid_in & ready_out & tracing;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (accept)         state_d = empty_vec ? IDLE : EMIT;
    else if (last_beat) state_d = IDLE;
  end

  // Output decode.
  always_comb begin
    valid_out  = (state_q == EMIT);
    ready_out  = (state_q == IDLE) | last_beat;
    vector_out = beat_q;
    length_out = beat_len_q;
  end

  // Next beat / residual buffer: load on accept, otherwise advance on each taken beat.
  always_comb begin
    buf_d      = buf_q;
    rem_d      = rem_q;
    len_d      = len_q;
    beat_d     = beat_q;
    beat_len_d = beat_len_q;
    if (accept & ~empty_vec) begin
      beat_d     = keep_lo(vin_shift, 32'(first_len));
      beat_len_d = first_len;
      buf_d      = shift_dn(vin_shift, 32'(first_len));
      rem_d      = cnt_sat - first_len;
      len_d      = fw_len;
    end else if (take) begin
      if (rem_q == '0) begin
        beat_d     = '0;
        beat_len_d = '0;
        buf_d      = '0;
      end else begin
        beat_d     = keep_lo(buf_q, 32'(step_len));
        beat_len_d = step_len;
        buf_d      = shift_dn(buf_q, 32'(step_len));
        rem_d      = rem_q - step_len;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      beat_len_q <= '0;
    end else begin
      buf_q      <= buf_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      beat_len_q <= beat_len_d;
    end
  end

  // Firmware table: a shift register loaded from the top on every matching configId.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_CHAINS; i++) fw_q[CHW'(i)] <= INITIAL_FIRMWARE[i*8 +: 8];
    end else if (configId == 8'(PERSONAL_CONFIG_ID)) begin
      for (int unsigned i = 0; i + 1 < MAX_CHAINS; i++) fw_q[CHW'(i)] <= fw_q[CHW'(i + 1)];
      fw_q[CHW'(MAX_CHAINS - 1)] <= configData;
    end
  end

`ifdef UNPACKER_STATS_EN
  logic [15:0] drop_q;

  // Saturating count of vectors consumed without producing a beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         drop_q <= '0;
    else if (accept & empty_vec & (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
  end

  assign dropped_count = drop_q;
`endif

endmodule
